// File: rtl/i2s_tx.sv
// I2S transmitter: divides clk into bclk/lrclk, latches one stereo pair per frame
// and shifts each channel out MSB-first with the standard one-bit delay.
module i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int BCLK_DIV   = 4,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] d_ch0,
  input  logic [DATA_WIDTH-1:0] d_ch1,
  output logic                  sample_clk,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_WIDTH);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] SLOT     = CNT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH);

  logic [DIV_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      next_cnt;
  logic [CNT_W-1:0]      pos;
  logic [DATA_WIDTH-1:0] hold_ch1;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  shift_evt;

  // Slot position refers to the bit count that takes effect on this shift event.
  always_comb begin
    shift_evt = bclk && (div_cnt == DIV_MAX);
    next_cnt  = (bit_cnt == CNT_MAX) ? '0 : bit_cnt + 1'b1;
    pos       = (next_cnt >= SLOT) ? next_cnt - SLOT : next_cnt;
  end

  // The left word goes straight from d_ch0 into the shift register at the frame
  // latch, so only the right word needs a holding register.
  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      bclk       <= 1'b0;
      bit_cnt    <= CNT_MAX;
      lrclk      <= 1'b0;
      sample_clk <= 1'b0;
      sdata      <= 1'b0;
      hold_ch1   <= '0;
      shreg      <= '0;
    end else if (!enable) begin
      div_cnt    <= '0;
      bclk       <= 1'b0;
      bit_cnt    <= CNT_MAX;
      lrclk      <= 1'b0;
      sample_clk <= 1'b0;
      sdata      <= 1'b0;
      hold_ch1   <= '0;
      shreg      <= '0;
    end else begin
      if (div_cnt == DIV_MAX) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (shift_evt) begin
        bit_cnt    <= next_cnt;
        lrclk      <= (next_cnt >= SLOT);
        sample_clk <= (next_cnt >= SLOT);
        if (next_cnt == '0) begin
          hold_ch1 <= d_ch1;
          shreg    <= d_ch0;
          sdata    <= 1'b0;
        end else if (next_cnt == SLOT) begin
          shreg <= hold_ch1;
          sdata <= 1'b0;
        end else if (pos <= LAST_BIT) begin
          sdata <= shreg[DATA_WIDTH-1];
          shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
        end else begin
          sdata <= 1'b0;
        end
      end
    end
  end

endmodule
